alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Control and result-capture stage wrapped around the 32-bit ALU's per-bit 8:1 result-select mux bank.
- Accepts one operation request at a time over a valid/ready handshake and registers the operands.
- Drives the 3-bit select shared by all 32 result muxes, starts and waits on the multi-cycle multiplier when needed, then captures the mux-bank output with flags into a result register presented over a second valid/ready handshake.

Parameters:
- WIDTH, 32, operand and result width; must match the mux bank width.
- MUL_OP, 3'b101, opcode whose result comes from the multi-cycle multiplier.
- MUL_TIMEOUT, 64, max cycles to wait for mul_done before aborting with error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  3  opcode; used directly as mux select.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- op_a  output  WIDTH  registered operand A to the datapath.
- op_b  output  WIDTH  registered operand B to the datapath.
- sel  output  3  registered select to every bit's 8:1 result mux.
- mux_result  input  WIDTH  output of the mux bank.
- mul_start  output  1  one-cycle multiplier start pulse.
- mul_done  input  1  multiplier result valid; level, sampled only in MULW.
- res_valid  output  1  result register holds an undelivered result.
- res_ready  input  1  consumer accepts the result.
- result  output  WIDTH  captured mux_result.
- zero  output  1  result == 0.
- err  output  1  multiplier timeout on this result.

Behaviour:
- Reset (asynchronous, active-high, clk not required) forces all registered outputs to 0:
  - state=IDLE, op_a=op_b=0, sel=0, mul_start=0, res_valid=0, result=0, zero=0, err=0, timeout counter=0.
  - Reset mid-operation abandons the operation; no result is produced.
- req_ready is combinational: 1 iff state==IDLE.
- States:
  - IDLE:
    - On req_valid && req_ready at a rising edge, latch req_a→op_a, req_b→op_b, req_op→sel.
    - Go to MULW if req_op==MUL_OP, else EXEC.
    - Entering MULW: mul_start=1 for exactly the first MULW cycle; counter cleared.
  - EXEC (one cycle; mux bank settles on registered sel/operands):
    - At its closing edge, result<=mux_result, zero<=(mux_result==0), err<=0, res_valid<=1.
    - Go to DONE.
  - MULW:
    - Counter increments each cycle.
    - If mul_done==1 at an edge: capture as in EXEC, go to DONE. mul_done in the first MULW cycle, the same cycle as mul_start, is honoured.
    - If the counter reaches MUL_TIMEOUT-1 without mul_done: result<=0, zero<=1, err<=1, res_valid<=1, go to DONE.
    - mul_done and timeout on the same edge: mul_done wins, err=0.
  - DONE:
    - Outputs held stable.
    - On res_valid && res_ready at an edge: res_valid<=0, go to IDLE.
    - result/zero/err retain their values until the next capture.
- Latency:
  - Accept at edge E (non-MUL) → res_valid high after edge E+1.
  - MUL with mul_done first seen at MULW edge k (k≥1) → res_valid high after edge E+k.
- No pipelining: req_ready stays 0 from acceptance until the result is consumed, so a new request cannot be accepted in the edge that consumes a result.
- op_a, op_b and sel are held constant from acceptance through DONE; they change only on a new acceptance.
- req_valid while not ready is ignored; the requester must hold it.
- mul_done outside MULW is ignored.
- Widths: zero is a full-width NOR of the captured value. No arithmetic is performed here.

Test Plan:
- Reset during DONE with res_valid=1 → all outputs 0 immediately, before the next clk edge; req_ready=1.
- ADD request: op=3'b010, a=5, b=7, bench models mux_result=12 when sel==010 → sel=010 after acceptance edge; res_valid=1 one edge later; result=12, zero=0, err=0.
- Back-to-back with backpressure:
  - XOR a=b=32'hA5A5A5A5, mux_result=0, res_ready held 0 for 3 cycles → result=0 and zero=1 held stable, req_ready=0 throughout.
  - After res_ready=1: IDLE, then a second request accepted.
- MUL: op=MUL_OP, a=3, b=4, mul_done asserted on the 5th MULW cycle with mux_result=12 → mul_start high exactly one cycle; result=12, err=0.
- MUL timeout: mul_done never asserted → after MUL_TIMEOUT (64) cycles in MULW, res_valid=1, result=0, zero=1, err=1.
- Asynchronous reset pulse mid-MULW (cycle 10) → state IDLE, mul_start=0, res_valid=0; a later mul_done pulse in IDLE has no effect.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: one-at-a-time op sequencer driving the ALU result-mux select and capturing its output.
// Ports: clk/reset (async, active-high); req_valid/req_ready/req_op/req_a/req_b request handshake;
// op_a/op_b/sel registered datapath drive; mux_result mux-bank output; mul_start/mul_done multiplier
// control; res_valid/res_ready/result/zero/err result handshake with flags.
module alu_op_sequencer #(
  parameter int         WIDTH       = 32,
  parameter logic [2:0] MUL_OP      = 3'b101,
  parameter int         MUL_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [2:0]       sel,
  input  logic [WIDTH-1:0] mux_result,
  output logic             mul_start,
  input  logic             mul_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);
  localparam int CW = $clog2(MUL_TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(MUL_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, EXEC, MULW, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [2:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mul_start_q, mul_start_d, res_valid_q, res_valid_d, zero_q, zero_d, err_q, err_d;
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    mul_start_d = 1'b0;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    err_d       = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        op_a_d      = req_a;
        op_b_d      = req_b;
        sel_d       = req_op;
        cnt_d       = '0;
        mul_start_d = req_op == MUL_OP;
        state_d     = req_op == MUL_OP ? MULW : EXEC;
      end
      EXEC: begin
        result_d    = mux_result;
        zero_d      = ~|mux_result;
        err_d       = 1'b0;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      MULW: begin
        cnt_d = cnt_q + 1'b1;
        // mul_done takes priority over a timeout landing on the same edge
        if (mul_done || cnt_q == TMAX) begin
          result_d    = mul_done ? mux_result : '0;
          zero_d      = mul_done ? ~|mux_result : 1'b1;
          err_d       = ~mul_done;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      default: if (res_ready) begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      mul_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      mul_start_q <= mul_start_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign sel       = sel_q;
  assign mul_start = mul_start_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign err       = err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer with a behavioural mux-bank model.
module tb_alu_op_sequencer;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic req_valid = 0, req_ready, mul_start, mul_done = 0, res_valid, res_ready = 0, zero, err;
  logic [2:0] req_op = 0, sel;
  logic [31:0] req_a = 0, req_b = 0, op_a, op_b, mux_result, result;
  typedef struct packed {logic [31:0] r; logic z; logic e;} exp_t;
  exp_t q[$];
  exp_t x;
  int checks = 0, errors = 0, starts = 0, n;

  alu_op_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b), .sel(sel), .mux_result(mux_result),
    .mul_start(mul_start), .mul_done(mul_done), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .zero(zero), .err(err)
  );

  always_comb begin
    case (sel)
      3'b000: mux_result = op_a & op_b;
      3'b001: mux_result = op_a | op_b;
      3'b010: mux_result = op_a + op_b;
      3'b011: mux_result = op_a ^ op_b;
      3'b100: mux_result = op_a - op_b;
      3'b101: mux_result = op_a * op_b;
      3'b110: mux_result = op_a << op_b[4:0];
      default: mux_result = ~op_a;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (mul_start) starts++;
    if (!reset && res_valid && res_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h want none", result);
      end else begin
        x = q.pop_front();
        chk("sb_result", result, x.r);
        chk("sb_zero", 32'(zero), 32'(x.z));
        chk("sb_err", 32'(err), 32'(x.e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    while (!req_ready && k < 200) begin
      tick();
      k++;
    end
    chk("ready_before_send", 32'(req_ready), 1);
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 0;
    chk("sel", 32'(sel), 32'(op));
    chk("op_a", op_a, a);
    chk("op_b", op_b, b);
    chk("ready_busy", 32'(req_ready), 0);
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("res_valid_wait", 32'(res_valid), 1);
  endtask

  initial begin
    #2;
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_mul_start", 32'(mul_start), 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    #10 reset = 0;
    tick();
    res_ready = 1;
    q.push_back('{32'd12, 1'b0, 1'b0});
    send(3'b010, 32'd5, 32'd7);
    chk("add_lat_exec", 32'(res_valid), 0);
    tick();
    chk("add_lat_done", 32'(res_valid), 1);
    tick();
    chk("add_back_idle", 32'(req_ready), 1);
    res_ready = 0;
    send(3'b000, 32'hF0, 32'h3C);
    wait_res(n);
    chk("and_pre_reset_result", result, 32'h30);
    #3 reset = 1;
    #1;
    chk("rstd_res_valid", 32'(res_valid), 0);
    chk("rstd_result", result, 0);
    chk("rstd_zero", 32'(zero), 0);
    chk("rstd_err", 32'(err), 0);
    chk("rstd_sel", 32'(sel), 0);
    chk("rstd_op_a", op_a, 0);
    chk("rstd_req_ready", 32'(req_ready), 1);
    #1 reset = 0;
    tick();
    q.push_back('{32'd0, 1'b1, 1'b0});
    send(3'b011, 32'hA5A5A5A5, 32'hA5A5A5A5);
    wait_res(n);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(res_valid), 1);
      chk("bp_result", result, 0);
      chk("bp_zero", 32'(zero), 1);
      chk("bp_ready", 32'(req_ready), 0);
      tick();
    end
    res_ready = 1;
    tick();
    chk("bp_idle", 32'(req_ready), 1);
    q.push_back('{32'd3, 1'b0, 1'b0});
    send(3'b001, 32'd1, 32'd2);
    wait_res(n);
    tick();
    starts = 0;
    q.push_back('{32'd12, 1'b0, 1'b0});
    send(3'b101, 32'd3, 32'd4);
    chk("mul_start_first", 32'(mul_start), 1);
    repeat (4) tick();
    chk("mul_wait_valid", 32'(res_valid), 0);
    chk("mul_start_low", 32'(mul_start), 0);
    mul_done = 1;
    tick();
    mul_done = 0;
    chk("mul_done_valid", 32'(res_valid), 1);
    chk("mul_start_count", starts, 1);
    tick();
    q.push_back('{32'd0, 1'b1, 1'b1});
    send(3'b101, 32'd6, 32'd7);
    wait_res(n);
    chk("timeout_cycles", n, 64);
    tick();
    send(3'b101, 32'd2, 32'd2);
    repeat (9) tick();
    #2 reset = 1;
    #1;
    chk("mrst_req_ready", 32'(req_ready), 1);
    chk("mrst_mul_start", 32'(mul_start), 0);
    chk("mrst_res_valid", 32'(res_valid), 0);
    chk("mrst_sel", 32'(sel), 0);
    #1 reset = 0;
    tick();
    mul_done = 1;
    tick();
    mul_done = 0;
    chk("stray_done_valid", 32'(res_valid), 0);
    chk("stray_done_ready", 32'(req_ready), 1);
    tick();
    chk("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
